cla_wide_seq_adder: RTL and testbench
=====================================

// Module: cla_wide_seq_adder
// PURPOSE
//   Multi-limb sequential adder built around the existing CLA_16 stage. Captures two
//   N_LIMBS*16-bit operands, feeds one 16-bit limb per cycle into a single CLA_16
//   instance (LSB limb first), chains the carry through a register and assembles the
//   wide sum. Provides a start/ready input handshake and a valid/ack result handshake.
// PARAMETERS
//   N_LIMBS   4   number of 16-bit limbs; operand width W = 16*N_LIMBS; legal range 2..16
// PORTS
//   CLK_in     in   1   single clock, rising edge
//   RSTn_in    in   1   asynchronous reset, active-low
//   Start_in   in   1   operand valid; accepted only when Start_in && Ready_out
//   A_in       in   W   operand A, sampled on accept
//   B_in       in   W   operand B, sampled on accept
//   C_in       in   1   carry-in into limb 0, sampled on accept
//   Ready_out  out  1   1 = IDLE, can accept
//   Valid_out  out  1   result valid; held until Ack_in
//   Ack_in     in   1   result consumed; honoured only while Valid_out=1
//   S_out      out  W   wide sum
//   C_out      out  1   carry out of MSB limb
//   Ovf_out    out  1   signed overflow: (a_msb==b_eff_msb) && (s_msb!=a_msb)
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE; Ready_out=1; Valid_out=0;
//     S_out=0; C_out=0; Ovf_out=0; limb counter=0; carry reg=0.
//   FSM: IDLE -(Start_in)-> RUN -(counter==N_LIMBS-1, same edge)-> DONE -(Ack_in)-> IDLE.
//   Accept edge: latch A, B into operand regs; carry reg <= C_in; counter <= 0.
//   RUN, each edge: CLA_16 gets A[k], B[k], carry reg for k=counter;
//     S limb k <= sum; carry reg <= CLA carry-out; counter++.
//   Latency: Valid_out rises exactly N_LIMBS edges after the accept edge.
//     S_out, C_out and Ovf_out are updated on that same edge.
//   S_out/C_out/Ovf_out are stable from Valid_out rise until the Ack edge.
//     They keep their last value in IDLE and are not cleared on Ack.
//   Ack_in outside DONE is ignored. Start_in outside IDLE is ignored;
//     operands are not re-sampled.
//   Ready_out is 0 through RUN and DONE. The Ack edge returns to IDLE, so Ready_out=1
//     on the next cycle. No accept is possible in the Ack cycle (no back-to-back).
//   Carry wrap: the carry out of the MSB limb goes to C_out only; it never re-enters limb 0.
//   Reset mid-RUN or mid-DONE: the operation is aborted, all outputs return to reset values,
//     and no Valid_out is produced for the aborted request.
// CONFIGURATION
//   CLA_WIDE_SUB_EN defined:
//     - Adds port Sub_in (in, 1), sampled on accept.
//     - Sub_in=1: B_eff = ~B and the carry-in is forced to 1 (C_in ignored), so S = A-B.
//       C_out=1 means no borrow. Ovf_out uses B_eff.
//     - Sub_in=0: identical to add mode.
//   CLA_WIDE_SUB_EN undefined: no Sub_in port; add-only; B_eff = B.
// STRUCTURE
//   Shared package cla_pkg: LIMB_W=16; FSM state encoding IDLE/RUN/DONE (2-bit);
//     limb-select function returning limb k of a W-bit vector.
//   One sub-module: the existing CLA_16 (A_in, B_in, C_in, S_out, C_out), instantiated once.
//   Counter width $clog2(N_LIMBS). No other hierarchy.
// TESTING (N_LIMBS=4 unless noted)
//   1. A=B=0x7FF8 (32760), C_in=0 -> after 4 edges Valid_out=1, S=0xFFF0, C_out=0, Ovf=0.
//   2. A=0xFFFF_FFFF_FFFF_FFFF, B=0, C_in=1 -> S=0, C_out=1, Ovf=0 (full ripple chain).
//   3. A=0x7FFF_FFFF_FFFF_FFFF, B=1, C_in=0 -> S=0x8000_0000_0000_0000, C_out=0, Ovf=1.
//   4. Start_in pulsed in RUN with other data, Ack_in held 0 for 5 cycles in DONE
//      -> result unchanged; Valid_out held; Ready_out=1 the cycle after Ack.
//   5. RSTn_in low 2 cycles after accept -> Ready_out=1, Valid_out=0, S_out=0;
//      a new request then completes correctly.
//   6. CLA_WIDE_SUB_EN defined, Sub_in=1, A=5, B=7 -> S=0xFFFF_FFFF_FFFF_FFFE,
//      C_out=0, Ovf=0.

Source files
------------

// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared limb width, FSM encoding and limb-select helper for the wide sequential adder
package cla_pkg;

    localparam int LIMB_W    = 16;
    localparam int MAX_LIMBS = 16;
    localparam int MAX_W     = LIMB_W * MAX_LIMBS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Callers zero-extend their operand to MAX_W so one helper serves every N_LIMBS.
    function automatic logic [LIMB_W-1:0] limb_sel(input logic [MAX_W-1:0] v, input logic [3:0] k);
        return v[k*LIMB_W +: LIMB_W];
    endfunction

endpackage

// File: rtl/cla_wide_seq_adder_cla16.sv
// rtl/cla_wide_seq_adder_cla16.sv - 16-bit carry-lookahead adder stage (4 groups of 4 bits)
module CLA_16
    import cla_pkg::*;
(
    input  logic [LIMB_W-1:0] A_in,
    input  logic [LIMB_W-1:0] B_in,
    input  logic              C_in,
    output logic [LIMB_W-1:0] S_out,
    output logic              C_out
);

    logic [LIMB_W-1:0] g;
    logic [LIMB_W-1:0] p;
    logic [3:0]        gg;
    logic [3:0]        gp;
    logic [4:0]        gc;
    logic [LIMB_W:0]   c;

    // Bit generate/propagate, group lookahead, then per-bit carries inside each group.
    always_comb begin
        g = A_in & B_in;
        p = A_in ^ B_in;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
        gc[0] = C_in;
        gc[1] = gg[0] | (gp[0] & C_in);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & C_in);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & C_in);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0]) | (gp[3] & gp[2] & gp[1] & gp[0] & C_in);
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j] = gc[j];
            for (int i = 0; i < 3; i++) begin
                c[4*j+i+1] = g[4*j+i] | (p[4*j+i] & c[4*j+i]);
            end
        end
        c[LIMB_W] = gc[4];
        S_out = p ^ c[LIMB_W-1:0];
        C_out = c[LIMB_W];
    end

endmodule

// File: rtl/cla_wide_seq_adder.sv
// rtl/cla_wide_seq_adder.sv - multi-limb sequential adder on one CLA_16; optional subtract via CLA_WIDE_SUB_EN
module cla_wide_seq_adder
    import cla_pkg::*;
#(
    parameter int N_LIMBS = 4
) (
    input  logic                       CLK_in,
    input  logic                       RSTn_in,
`ifdef CLA_WIDE_SUB_EN
    input  logic                       Sub_in,
`endif
    input  logic                       Start_in,
    input  logic [LIMB_W*N_LIMBS-1:0]  A_in,
    input  logic [LIMB_W*N_LIMBS-1:0]  B_in,
    input  logic                       C_in,
    output logic                       Ready_out,
    output logic                       Valid_out,
    input  logic                       Ack_in,
    output logic [LIMB_W*N_LIMBS-1:0]  S_out,
    output logic                       C_out,
    output logic                       Ovf_out
);

    localparam int W     = LIMB_W * N_LIMBS;
    localparam int CNT_W = $clog2(N_LIMBS);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic               carry_q;
    logic [W-1:0]       work_q;
    logic [W-1:0]       work_d;
    logic [W-1:0]       s_q;
    logic               c_q;
    logic               ovf_q;

    logic [W-1:0]       b_eff;
    logic               cin_eff;
    logic               accept;
    logic               last_limb;
    logic [LIMB_W-1:0]  cla_a;
    logic [LIMB_W-1:0]  cla_b;
    logic [LIMB_W-1:0]  cla_s;
    logic               cla_co;

    assign accept    = (state_q == ST_IDLE) && Start_in;
    assign last_limb = (cnt_q == CNT_W'(N_LIMBS-1));

    // Operand conditioning at accept: subtract is A + ~B + 1, so B is inverted and carry-in forced.
    always_comb begin
`ifdef CLA_WIDE_SUB_EN
        b_eff   = Sub_in ? ~B_in : B_in;
        cin_eff = Sub_in ? 1'b1 : C_in;
`else
        b_eff   = B_in;
        cin_eff = C_in;
`endif
    end

    assign cla_a = limb_sel(MAX_W'(a_q), 4'(cnt_q));
    assign cla_b = limb_sel(MAX_W'(b_q), 4'(cnt_q));

    CLA_16 u_cla (
        .A_in  (cla_a),
        .B_in  (cla_b),
        .C_in  (carry_q),
        .S_out (cla_s),
        .C_out (cla_co)
    );

    // Work sum with the current limb merged in; on the last limb this is the finished result.
    always_comb begin
        work_d = work_q;
        for (int k = 0; k < N_LIMBS; k++) begin
            if (cnt_q == CNT_W'(k)) begin
                work_d[k*LIMB_W +: LIMB_W] = cla_s;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge CLK_in or negedge RSTn_in) begin
        if (!RSTn_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: Start outside IDLE and Ack outside DONE fall through to "stay".
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (Start_in)  state_d = ST_RUN;
            ST_RUN:  if (last_limb) state_d = ST_DONE;
            ST_DONE: if (Ack_in)    state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        Ready_out = (state_q == ST_IDLE);
        Valid_out = (state_q == ST_DONE);
    end

    // Datapath: capture on accept, one limb per RUN edge; published results change only on the last limb.
    always_ff @(posedge CLK_in or negedge RSTn_in) begin
        if (!RSTn_in) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            work_q  <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            a_q     <= A_in;
            b_q     <= b_eff;
            carry_q <= cin_eff;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            work_q  <= work_d;
            carry_q <= cla_co;
            cnt_q   <= cnt_q + 1'b1;
            if (last_limb) begin
                s_q   <= work_d;
                c_q   <= cla_co;
                ovf_q <= (a_q[W-1] == b_q[W-1]) && (cla_s[LIMB_W-1] != a_q[W-1]);
            end
        end
    end

    assign S_out   = s_q;
    assign C_out   = c_q;
    assign Ovf_out = ovf_q;

endmodule

// File: tb/tb_cla_wide_seq_adder.sv
// tb/tb_cla_wide_seq_adder.sv - scoreboard bench for cla_wide_seq_adder (N_LIMBS=4, CLA_WIDE_SUB_EN optional)
module tb_cla_wide_seq_adder;

    localparam int N = 4;
    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         c_in;
    logic         ack;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         valid;
    logic         c_out;
    logic         ovf;
    logic [W-1:0] s;
`ifdef CLA_WIDE_SUB_EN
    logic         sub;
`endif

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cla_wide_seq_adder #(.N_LIMBS(N)) dut (
        .CLK_in    (clk),
        .RSTn_in   (rst_n),
`ifdef CLA_WIDE_SUB_EN
        .Sub_in    (sub),
`endif
        .Start_in  (start),
        .A_in      (a),
        .B_in      (b),
        .C_in      (c_in),
        .Ready_out (ready),
        .Valid_out (valid),
        .Ack_in    (ack),
        .S_out     (s),
        .C_out     (c_out),
        .Ovf_out   (ovf)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pop expected on each Valid rise, then hold-check while Valid stays high.
    initial begin
        exp_t cur;
        bit   have;
        logic pv;
        have = 0;
        pv   = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                have = 0;
            end else if (valid && !pv) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 64'(valid), 64'd0);
                    have = 0;
                end else begin
                    cur  = sb.pop_front();
                    have = 1;
                    chk("sum", s, cur.s);
                    chk("cout", 64'(c_out), 64'(cur.c));
                    chk("ovf", 64'(ovf), 64'(cur.o));
                    chk("latency", 64'(cyc - cur.acc_cyc), 64'(N));
                end
            end else if (valid && have) begin
                chk("hold_sum", s, cur.s);
                chk("hold_cout", 64'(c_out), 64'(cur.c));
            end
            pv = valid;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!ready) chk("ready_timeout", 64'(ready), 64'd1);
    endtask

    task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc, input logic tsub,
                      input logic [W-1:0] es, input logic ec, input logic eo,
                      input int hold, input bit poke);
        exp_t e;
        int   n;
        wait_ready();
        a     = ta;
        b     = tb_v;
        c_in  = tc;
`ifdef CLA_WIDE_SUB_EN
        sub   = tsub;
`else
        if (tsub) $display("note: subtract vector skipped in add-only build");
`endif
        start = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        e.s       = es;
        e.c       = ec;
        e.o       = eo;
        e.acc_cyc = cyc;
        sb.push_back(e);
        chk("ready_in_run", 64'(ready), 64'd0);
        if (poke) begin
            a     = ~ta;
            b     = ~tb_v;
            c_in  = ~tc;
            start = 1'b1;
            ack   = 1'b1;
            @(negedge clk);
            start = 1'b0;
            ack   = 1'b0;
        end
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!valid) chk("valid_timeout", 64'(valid), 64'd1);
        repeat (hold) @(negedge clk);
        chk("valid_held", 64'(valid), 64'd1);
        chk("ready_in_done", 64'(ready), 64'd0);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ready_after_ack", 64'(ready), 64'd1);
        chk("valid_after_ack", 64'(valid), 64'd0);
        chk("sum_kept_idle", s, es);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        ack   = 1'b0;
        c_in  = 1'b0;
        a     = '0;
        b     = '0;
`ifdef CLA_WIDE_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_sum", s, 64'd0);
        chk("rst_cout", 64'(c_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        op(64'h0000_0000_0000_7FF8, 64'h0000_0000_0000_7FF8, 1'b0, 1'b0,
           64'h0000_0000_0000_FFF0, 1'b0, 1'b0, 0, 0);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0,
           64'h0, 1'b1, 1'b0, 0, 0);
        op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0,
           64'h8000_0000_0000_0000, 1'b0, 1'b1, 1, 0);
        op(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b0,
           64'h2222_2222_2222_2211, 1'b0, 1'b0, 0, 0);
        op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
           64'h0, 1'b1, 1'b1, 0, 0);
        op(64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1, 1'b0,
           64'h0011_0022_0033_0045, 1'b0, 1'b0, 5, 1);

        wait_ready();
        a     = 64'h5555_5555_5555_5555;
        b     = 64'h5555_5555_5555_5555;
        c_in  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(ready), 64'd1);
        chk("abort_valid", 64'(valid), 64'd0);
        chk("abort_sum", s, 64'd0);
        chk("abort_cout", 64'(c_out), 64'd0);
        chk("abort_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_valid", 64'(valid), 64'd0);
        op(64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0,
           64'h0000_0000_0001_0000, 1'b0, 1'b0, 0, 0);

`ifdef CLA_WIDE_SUB_EN
        op(64'h5, 64'h7, 1'b0, 1'b1,
           64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0, 0);
        op(64'h7, 64'h5, 1'b0, 1'b1,
           64'h2, 1'b1, 1'b0, 0, 0);
        op(64'h8000_0000_0000_0000, 64'h1, 1'b0, 1'b1,
           64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 0);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
